// File: rtl/imem_loader.sv
// Instruction memory loader: streams 32-bit words into a byte-wide write port, little-endian.
// Optional IMEM_LOADER_CHECKSUM_EN adds exp_sum/sum_ok and a wrapping sum of loaded words.
module imem_loader #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned MEM_BYTES = 512,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       word_count,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic [31:0]       exp_sum,
  output logic              sum_ok,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    widx;
  logic [WORD_W-1:0]   word_q;
  logic [1:0]          b;

  logic [ADDR_W-1:0]   end_addr_c;
  logic [ADDR_W-1:0]   word_addr_c;
  logic                overflow_c;
  logic [CNT_W-1:0]    widx_inc_c;
  logic [1:0]          b_inc_c;
  logic                last_word_c;
  logic                start_acc_c;

  // Session bounds and address helpers, all ADDR_W wide
  always_comb begin
    end_addr_c  = ADDR_W'(BASE_ADDR) + (ADDR_W'(word_count) << 2);
    overflow_c  = end_addr_c > ADDR_W'(MEM_BYTES);
    word_addr_c = ADDR_W'(BASE_ADDR) + (ADDR_W'(widx) << 2);
    widx_inc_c  = widx + CNT_W'(1);
    b_inc_c     = b + 2'd1;
    last_word_c = (widx_inc_c == count_q);
    start_acc_c = start && ((state == IDLE) || (state == DONE));
  end

  // Loader FSM with registered outputs; byte 0 is issued on the handshake edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count_q   <= '0;
      widx      <= '0;
      word_q    <= '0;
      b         <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_q <= word_count;
            widx    <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            if (overflow_c) begin
              state <= DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (word_count == CNT_W'(0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            word_q    <= in_word;
            b         <= 2'd0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= word_addr_c;
            mem_wdata <= in_word[BYTE_W-1:0];
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (b == 2'd3) begin
            mem_we <= 1'b0;
            widx   <= widx_inc_c;
            if (last_word_c) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
            end
          end else begin
            b         <= b_inc_c;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= BYTE_W'(word_q >> {b_inc_c, 3'b000});
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
  logic [WORD_W-1:0] exp_q;

  // Wrapping sum of accepted words; sum_ok is only meaningful once DONE is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      exp_q  <= '0;
      sum_ok <= 1'b0;
    end else if (start_acc_c) begin
      sum_q  <= '0;
      exp_q  <= exp_sum;
      sum_ok <= (overflow_c || (word_count == CNT_W'(0))) ? (exp_sum == WORD_W'(0)) : 1'b0;
    end else if ((state == ACCEPT) && in_valid) begin
      sum_q <= sum_q + in_word;
    end else if ((state == WRITE) && (b == 2'd3) && last_word_c) begin
      sum_ok <= (sum_q == exp_q);
    end
  end
`else
  logic unused_c;
  assign unused_c = start_acc_c;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the byte-addressed instruction memory before the core runs. It accepts 32-bit instruction words over a valid/ready stream and writes each word as four bytes, little-endian, through the memory's byte write port. Byte `4k+0` receives `word[7:0]` and byte `4k+3` receives `word[31:24]`, which matches the fetch-side byte ordering. It holds the core off while loading and reports completion, overflow and, optionally, a checksum result.

## Interface
Parameters:
- `ADDR_W`, 64: width of `mem_addr`; matches the fetch address width.
- `MEM_BYTES`, 512: instruction memory size in bytes.
- `BASE_ADDR`, 0: byte address of the first loaded word; must be a multiple of 4.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load session; ignored while `busy`.
- `word_count`  in  16  number of words to load; sampled on accepted `start`.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_word`  in  32  instruction word.
- `mem_we`  out  1  byte write strobe.
- `mem_addr`  out  ADDR_W  byte address of the write.
- `mem_wdata`  out  8  byte to write.
- `busy`  out  1  a session is in progress.
- `cpu_hold`  out  1  equals `busy`; holds the core in reset.
- `done`  out  1  session finished; held until the next accepted `start`.
- `error`  out  1  the session was rejected for overflow; held like `done`.

## Operation
State machine: IDLE, ACCEPT, WRITE, DONE.
- **IDLE**
  - On `start`: latch `word_count`, clear `done`, `error` and the word index `widx`.
  - If `BASE_ADDR + 4*word_count > MEM_BYTES`: go to DONE with `error`=1 and perform no writes.
  - Else if `word_count`=0: go to DONE.
  - Else: go to ACCEPT.
- **ACCEPT**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_word`, set byte index `b`=0, go to WRITE.
- **WRITE**
  - `mem_we`=1.
  - `mem_addr` = `BASE_ADDR + 4*widx + b`.
  - `mem_wdata` = `word[8b+7:8b]`.
  - `b` increments each cycle.
  - After `b`=3, increment `widx`. If `widx` equals the count, go to DONE; else go to ACCEPT.
  - `in_ready`=0 throughout.
- **DONE**
  - `done`=1 and `busy`=0.
  - On `start`, behave exactly as IDLE does.
- Address arithmetic is ADDR_W wide. `widx` is 16 bits.
- `start` while `busy` has no effect.
- `in_valid` outside ACCEPT is ignored; that word is not consumed.

## Timing
- **Reset values:** state=IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `cpu_hold`=0, `done`=0, `error`=0.
- All outputs are registered.
- **Session start:** `start` sampled at edge 0 → `busy`=1 and `in_ready`=1 from cycle 1.
- **Per-word latency:** handshake at edge k → `mem_we`=1 during cycles k+1 through k+4, bytes 0 to 3 in order.
- **Next word:** `in_ready` returns in cycle k+5.
- **Throughput:** one word per 5 cycles with `in_valid` held high.
- **Completion:** `done` rises the cycle after the last byte write. The same cycle, `busy` and `cpu_hold` fall.
- **Overflow or zero count:** `done` rises at cycle 1; `mem_we` never asserts.
- **Reset mid-session:** immediate return to reset values. Bytes already written stay in memory. The partial word is lost.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - Adds port `exp_sum` (input, 32 bits), sampled on accepted `start`.
  - Adds port `sum_ok` (output, 1 bit).
  - A 32-bit wrapping sum of accepted words is cleared on `start`.
  - In DONE, `sum_ok` = (sum == `exp_sum`). `sum_ok` is 0 while busy and at reset.
  - A checksum mismatch does not set `error`.
- **Not defined:** neither port exists and no sum logic is built.

## Test plan
- **Single word:** `BASE_ADDR`=4, `word_count`=1, `in_word`=0x00010083 → writes 0x83@4, 0x00@5, 0x01@6, 0x00@7 on four consecutive cycles. `done`=1 the next cycle and `cpu_hold` falls.
- **Back-to-back words:** 4 words with `in_valid` held high → exactly 16 writes to addresses 0–15 in ascending order. `in_ready` pulses every 5 cycles. `done` 21 cycles after `start`.
- **Stalled source:** `in_valid` low for 10 cycles between words → no `mem_we` during the gap. `in_ready` stays high. Byte order is unchanged.
- **Overflow:** `MEM_BYTES`=512, `word_count`=129 → `error`=1 and `done`=1 at cycle 1, with zero writes. A following `start` with `word_count`=128 completes with `error`=0 and last write at address 511.
- **Reset mid-word:** assert `reset` after byte 1 of word 2 → all outputs 0 immediately. A new `start` restarts at `BASE_ADDR`.
- **Checksum (macro on):** words 0x1, 0xFFFFFFFF, `exp_sum`=0x0 → `sum_ok`=1. The same words with `exp_sum`=0x1 → `sum_ok`=0 and `error`=0.
